// File: rtl/alu_rx_ctrl.sv
// -----------------------------------------------------------------------------
// alu_rx_ctrl
// Byte-stream sequencer for the ALU. It collects three bytes from the UART
// receiver (operand A, operand B, opcode) into the ALU operand/opcode
// registers. One cycle later it captures the combinational ALU result and
// hands it to the UART transmitter.
//
// Ports:
//   clk_i       system clock, all logic on the rising edge
//   reset_i     synchronous active-high reset, overrides everything
//   rx_data_i   received byte
//   rx_valid_i  one-cycle strobe, rx_data_i valid this cycle
//   tx_busy_i   transmitter busy, tx_start_o held off while high
//   tx_data_o   registered byte to transmit
//   tx_start_o  one-cycle strobe to start transmission of tx_data_o
//   datoa_o     registered ALU operand A
//   datob_o     registered ALU operand B
//   opcode_o    registered ALU opcode (low SIZEOP bits of the third byte)
//   result_i    combinational ALU result
//   busy_o      high while executing or waiting to send
//   overrun_o   sticky flag, a byte arrived while busy_o was high
//
// Optional feature (macro ALU_CTRL_TIMEOUT_EN):
//   When defined, a partially received command is abandoned after
//   TIMEOUT_CYCLES idle cycles in WaitB/WaitOp. When undefined, the FSM
//   waits indefinitely for the remaining bytes.
// -----------------------------------------------------------------------------
module alu_rx_ctrl #(
  parameter int SIZEDATA = 8,
  parameter int SIZEOP   = 6
`ifdef ALU_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [SIZEDATA-1:0] rx_data_i,
  input  logic                rx_valid_i,
  input  logic                tx_busy_i,
  output logic [SIZEDATA-1:0] tx_data_o,
  output logic                tx_start_o,
  output logic [SIZEDATA-1:0] datoa_o,
  output logic [SIZEDATA-1:0] datob_o,
  output logic [SIZEOP-1:0]   opcode_o,
  input  logic [SIZEDATA-1:0] result_i,
  output logic                busy_o,
  output logic                overrun_o
);

  typedef enum logic [2:0] {
    WaitA,
    WaitB,
    WaitOp,
    Exec,
    Send
  } state_e;

  state_e              state_q, state_d;
  logic [SIZEDATA-1:0] datoa_q, datoa_d;
  logic [SIZEDATA-1:0] datob_q, datob_d;
  logic [SIZEOP-1:0]   opcode_q, opcode_d;
  logic [SIZEDATA-1:0] tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                overrun_q, overrun_d;
  logic                timeout;

`ifdef ALU_CTRL_TIMEOUT_EN
  localparam int CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Idle counter for the middle of a command. Any accepted byte, any other
  // state and the expiry itself bring it back to zero, so it always starts
  // from zero when WaitB is entered.
  assign timeout = (state_q == WaitB || state_q == WaitOp) && (cnt_q == CntLast);

  always_comb begin
    cnt_d = '0;
    if ((state_q == WaitB || state_q == WaitOp) && !rx_valid_i && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state and register-update logic. Registers hold by default so the
  // operand display keeps showing the last command. A byte that arrives
  // while executing or sending is dropped and only marks the overrun flag.
  always_comb begin
    state_d    = state_q;
    datoa_d    = datoa_q;
    datob_d    = datob_q;
    opcode_d   = opcode_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overrun_d  = overrun_q;
    unique case (state_q)
      WaitA: begin
        if (rx_valid_i) begin
          datoa_d = rx_data_i;
          state_d = WaitB;
        end
      end
      WaitB: begin
        if (rx_valid_i) begin
          datob_d = rx_data_i;
          state_d = WaitOp;
        end else if (timeout) begin
          state_d = WaitA;
        end
      end
      WaitOp: begin
        if (rx_valid_i) begin
          opcode_d = rx_data_i[SIZEOP-1:0];
          state_d  = Exec;
        end else if (timeout) begin
          state_d = WaitA;
        end
      end
      Exec: begin
        // The operand registers were loaded on the previous edge, so the
        // ALU result has had a full cycle to settle.
        tx_data_d = result_i;
        state_d   = Send;
        if (rx_valid_i) begin
          overrun_d = 1'b1;
        end
      end
      Send: begin
        if (rx_valid_i) begin
          overrun_d = 1'b1;
        end
        if (!tx_busy_i) begin
          tx_start_d = 1'b1;
          state_d    = WaitA;
        end
      end
      default: begin
        state_d = WaitA;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset discards any
  // partially collected command.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= WaitA;
      datoa_q    <= '0;
      datob_q    <= '0;
      opcode_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      datoa_q    <= datoa_d;
      datob_q    <= datob_d;
      opcode_q   <= opcode_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
    end
  end

  assign datoa_o    = datoa_q;
  assign datob_o    = datob_q;
  assign opcode_o   = opcode_q;
  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign overrun_o  = overrun_q;
  assign busy_o     = (state_q == Exec) || (state_q == Send);

endmodule

// File: tb/tb_alu_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_rx_ctrl
// Self-checking bench for alu_rx_ctrl. A small ALU model closes the loop from
// the operand registers to the result input; expected values come from the
// bytes the bench itself sends.
// -----------------------------------------------------------------------------
module tb_alu_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rxData;
  logic       rxValid;
  logic       txBusy;
  logic [7:0] txData;
  logic       txStart;
  logic [7:0] datoa;
  logic [7:0] datob;
  logic [5:0] opcode;
  logic [7:0] result;
  logic       busy;
  logic       overrun;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

`ifdef ALU_CTRL_TIMEOUT_EN
  alu_rx_ctrl #(.SIZEDATA(8), .SIZEOP(6), .TIMEOUT_CYCLES(16)) dut (
`else
  alu_rx_ctrl #(.SIZEDATA(8), .SIZEOP(6)) dut (
`endif
    .clk_i(clk), .reset_i(reset), .rx_data_i(rxData), .rx_valid_i(rxValid),
    .tx_busy_i(txBusy), .tx_data_o(txData), .tx_start_o(txStart),
    .datoa_o(datoa), .datob_o(datob), .opcode_o(opcode), .result_i(result),
    .busy_o(busy), .overrun_o(overrun));

  // Reference ALU behaviour for a handful of MIPS-style function codes.
  function automatic logic [7:0] aluModel(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return $signed(a) >>> b;
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  // Stand-in for the combinational ALU fed by the DUT registers.
  always_comb result = aluModel(datoa, datob, opcode);

  // Drives one byte strobe and returns at the negedge after it.
  task automatic putByte(input logic [7:0] b);
    @(negedge clk);
    rxData  = b;
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; rxValid = 1'b0; rxData = 8'h00; txBusy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    nCompared++; if (datoa !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_datoa: got %h expected 00", datoa); end
    nCompared++; if (datob !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_datob: got %h expected 00", datob); end
    nCompared++; if (opcode !== 6'h00) begin nMismatched++; $display("[TB] FAIL reset_opcode: got %h expected 00", opcode); end
    nCompared++; if (txData !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_txdata: got %h expected 00", txData); end
    nCompared++; if (txStart !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_txstart: got %b expected 0", txStart); end
    nCompared++; if (overrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic;
    logic expStart, expBusy;
    putByte(8'h05); putByte(8'h03); putByte(8'h20);
    nCompared++; if (datoa !== 8'h05) begin nMismatched++; $display("[TB] FAIL basic_datoa: got %h expected 05", datoa); end
    nCompared++; if (datob !== 8'h03) begin nMismatched++; $display("[TB] FAIL basic_datob: got %h expected 03", datob); end
    nCompared++; if (opcode !== 6'h20) begin nMismatched++; $display("[TB] FAIL basic_opcode: got %h expected 20", opcode); end
    nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_busy_exec: got %b expected 1", busy); end
    nCompared++; if (txStart !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_start_exec: got %b expected 0", txStart); end
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      expStart = (k == 3);
      expBusy  = (k == 2);
      nCompared++; if (txStart !== expStart) begin nMismatched++; $display("[TB] FAIL basic_start_c%0d: got %b expected %b", k, txStart, expStart); end
      nCompared++; if (busy !== expBusy) begin nMismatched++; $display("[TB] FAIL basic_busy_c%0d: got %b expected %b", k, busy, expBusy); end
      nCompared++; if (txData !== 8'h08) begin nMismatched++; $display("[TB] FAIL basic_txdata_c%0d: got %h expected 08", k, txData); end
    end
  endtask

  task automatic test_opcode_mask;
    putByte(8'h07); putByte(8'h09); putByte(8'hE0);
    nCompared++; if (opcode !== 6'h20) begin nMismatched++; $display("[TB] FAIL mask_opcode: got %h expected 20", opcode); end
    repeat (2) @(negedge clk);
    nCompared++; if (txStart !== 1'b1) begin nMismatched++; $display("[TB] FAIL mask_start: got %b expected 1", txStart); end
    nCompared++; if (txData !== 8'h10) begin nMismatched++; $display("[TB] FAIL mask_txdata: got %h expected 10", txData); end
  endtask

  task automatic test_tx_busy;
    txBusy = 1'b1;
    putByte(8'hFB); putByte(8'h02); putByte(8'h20);
    for (int k = 2; k <= 11; k++) begin
      @(negedge clk);
      nCompared++; if (txStart !== 1'b0) begin nMismatched++; $display("[TB] FAIL txbusy_start_c%0d: got %b expected 0", k, txStart); end
      nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL txbusy_busy_c%0d: got %b expected 1", k, busy); end
      nCompared++; if (txData !== 8'hFD) begin nMismatched++; $display("[TB] FAIL txbusy_txdata_c%0d: got %h expected fd", k, txData); end
    end
    txBusy = 1'b0;
    @(negedge clk);
    nCompared++; if (txStart !== 1'b1) begin nMismatched++; $display("[TB] FAIL txbusy_pulse: got %b expected 1", txStart); end
    nCompared++; if (txData !== 8'hFD) begin nMismatched++; $display("[TB] FAIL txbusy_txdata_pulse: got %h expected fd", txData); end
    @(negedge clk);
    nCompared++; if (txStart !== 1'b0) begin nMismatched++; $display("[TB] FAIL txbusy_pulse_end: got %b expected 0", txStart); end
  endtask

  task automatic test_overrun;
    nCompared++; if (overrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovr_initial: got %b expected 0", overrun); end
    putByte(8'h10); putByte(8'h30); putByte(8'h22);
    rxData = 8'h77; rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
    nCompared++; if (overrun !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovr_flag: got %b expected 1", overrun); end
    nCompared++; if (datoa !== 8'h10) begin nMismatched++; $display("[TB] FAIL ovr_datoa_kept: got %h expected 10", datoa); end
    @(negedge clk);
    nCompared++; if (txStart !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovr_start: got %b expected 1", txStart); end
    nCompared++; if (txData !== 8'hE0) begin nMismatched++; $display("[TB] FAIL ovr_txdata: got %h expected e0", txData); end
    putByte(8'h06); putByte(8'h07); putByte(8'h24);
    nCompared++; if (datoa !== 8'h06) begin nMismatched++; $display("[TB] FAIL ovr_next_datoa: got %h expected 06", datoa); end
    nCompared++; if (datob !== 8'h07) begin nMismatched++; $display("[TB] FAIL ovr_next_datob: got %h expected 07", datob); end
    repeat (2) @(negedge clk);
    nCompared++; if (txStart !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovr_next_start: got %b expected 1", txStart); end
    nCompared++; if (txData !== 8'h06) begin nMismatched++; $display("[TB] FAIL ovr_next_txdata: got %h expected 06", txData); end
    nCompared++; if (overrun !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovr_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_reset_midcmd;
    putByte(8'h11); putByte(8'h22);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nCompared++; if (datoa !== 8'h00) begin nMismatched++; $display("[TB] FAIL rst_datoa: got %h expected 00", datoa); end
    nCompared++; if (datob !== 8'h00) begin nMismatched++; $display("[TB] FAIL rst_datob: got %h expected 00", datob); end
    nCompared++; if (txData !== 8'h00) begin nMismatched++; $display("[TB] FAIL rst_txdata: got %h expected 00", txData); end
    nCompared++; if (overrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_overrun: got %b expected 0", overrun); end
    putByte(8'h01); putByte(8'h01); putByte(8'h20);
    nCompared++; if (opcode !== 6'h20) begin nMismatched++; $display("[TB] FAIL rst_opcode: got %h expected 20", opcode); end
    repeat (2) @(negedge clk);
    nCompared++; if (txStart !== 1'b1) begin nMismatched++; $display("[TB] FAIL rst_start: got %b expected 1", txStart); end
    nCompared++; if (txData !== 8'h02) begin nMismatched++; $display("[TB] FAIL rst_txdata_after: got %h expected 02", txData); end
  endtask

  task automatic test_timeout;
    putByte(8'h09);
    repeat (20) @(negedge clk);
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL tmo_busy_idle: got %b expected 0", busy); end
    putByte(8'h01); putByte(8'h02);
`ifdef ALU_CTRL_TIMEOUT_EN
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL tmo_busy_two: got %b expected 0", busy); end
    putByte(8'h20);
    nCompared++; if (datoa !== 8'h01) begin nMismatched++; $display("[TB] FAIL tmo_datoa: got %h expected 01", datoa); end
    nCompared++; if (datob !== 8'h02) begin nMismatched++; $display("[TB] FAIL tmo_datob: got %h expected 02", datob); end
    repeat (2) @(negedge clk);
    nCompared++; if (txStart !== 1'b1) begin nMismatched++; $display("[TB] FAIL tmo_start: got %b expected 1", txStart); end
    nCompared++; if (txData !== 8'h03) begin nMismatched++; $display("[TB] FAIL tmo_txdata: got %h expected 03", txData); end
`else
    nCompared++; if (datoa !== 8'h09) begin nMismatched++; $display("[TB] FAIL notmo_datoa: got %h expected 09", datoa); end
    nCompared++; if (datob !== 8'h01) begin nMismatched++; $display("[TB] FAIL notmo_datob: got %h expected 01", datob); end
    nCompared++; if (opcode !== 6'h02) begin nMismatched++; $display("[TB] FAIL notmo_opcode: got %h expected 02", opcode); end
    repeat (2) @(negedge clk);
    nCompared++; if (txStart !== 1'b1) begin nMismatched++; $display("[TB] FAIL notmo_start: got %b expected 1", txStart); end
    nCompared++; if (txData !== 8'h04) begin nMismatched++; $display("[TB] FAIL notmo_txdata: got %h expected 04", txData); end
`endif
  endtask

  task automatic test_random;
    logic [5:0] opList [8];
    logic [7:0] a, b, expData;
    logic [5:0] op;
    logic [1:0] hi;
    int bc, expPulse;
    opList = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
    for (int it = 0; it < 24; it++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      op = opList[$urandom_range(0, 7)];
      hi = 2'($urandom_range(0, 3));
      bc = $urandom_range(0, 6);
      expData  = aluModel(a, b, op);
      expPulse = (bc + 2 > 3) ? bc + 2 : 3;
      txBusy = 1'b1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      putByte(a);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      putByte(b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      putByte({hi, op});
      nCompared++; if (datoa !== a) begin nMismatched++; $display("[TB] FAIL rand%0d_datoa: got %h expected %h", it, datoa, a); end
      nCompared++; if (datob !== b) begin nMismatched++; $display("[TB] FAIL rand%0d_datob: got %h expected %h", it, datob, b); end
      nCompared++; if (opcode !== op) begin nMismatched++; $display("[TB] FAIL rand%0d_opcode: got %h expected %h", it, opcode, op); end
      if (bc == 0) txBusy = 1'b0;
      for (int n = 2; n <= expPulse + 1; n++) begin
        @(negedge clk);
        nCompared++; if (txStart !== (n == expPulse)) begin nMismatched++; $display("[TB] FAIL rand%0d_start_c%0d: got %b expected %b", it, n, txStart, (n == expPulse)); end
        if (n == expPulse) begin
          nCompared++; if (txData !== expData) begin nMismatched++; $display("[TB] FAIL rand%0d_txdata: got %h expected %h", it, txData, expData); end
        end
        if (n == 1 + bc) txBusy = 1'b0;
      end
    end
    txBusy = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_opcode_mask;
    test_tx_busy;
    test_overrun;
    test_reset_midcmd;
    test_timeout;
    test_random;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
